sdram_nios2_qsys_oci_dct_packer: RTL
====================================

// Module: sdram_nios2_qsys_oci_dct_packer
// PURPOSE
//  Upstream producer of the OCI debug-compressed-trace (DCT) stage: packs 2-bit trace codes
//  into the 30-bit dct_buffer / 4-bit dct_count pair consumed by the OCI test bench / trace store.
//  Emits one frame per 15 codes, or on flush, to the trace memory over a valid/ready port.
//  Drops codes and flags overflow when the frame register is still held by backpressure.
// PARAMETERS
//  DROP_CNT_W   8    width of saturating dropped-code counter
//  TS_WIDTH     16   timestamp width; used only with SDRAM_NIOS2_QSYS_OCI_DCT_TS_EN
// PORTS
//  clk          in   1         single clock; all logic is rising-edge
//  reset        in   1         synchronous, active-high reset
//  trc_en       in   1         1 = accept codes; 0 = code_valid ignored, flush still honoured
//  code_valid   in   1         code qualifier
//  code         in   2         trace code, packed into the LSBs
//  flush        in   1         emit a partial frame if dct_count != 0
//  dct_buffer   out  30        live accumulation buffer
//  dct_count    out  4         live code count, 0..14
//  frm_valid    out  1         frame register holds an unconsumed frame
//  frm_ready    in   1         consumer accepts the frame when frm_valid & frm_ready
//  frm_data     out  34(+TS)   {count[3:0], buffer[29:0]} (+ {ts} MSBs with TS_EN)
//  overflow     out  1         sticky; set when a code or frame is dropped
//  ovf_clr      in   1         clears overflow and drop_cnt
//  drop_cnt     out  DROP_CNT_W saturating count of dropped codes
// BEHAVIOUR
//  - Reset: dct_buffer=0, dct_count=0, frm_valid=0, frm_data=0, overflow=0, drop_cnt=0, ts=0.
//    A pending unconsumed frame is discarded.
//  - Accept (trc_en & code_valid): nb={dct_buffer[27:0],code}, nc=dct_count+1; otherwise nb/nc =
//    current values.
//  - Emit: condition is nc==15 OR (flush & nc!=0). The frame is {nc,nb}. Buffer/count clear to 0 the
//    same cycle. The frame register loads the next cycle: frm_valid=1 one cycle after the
//    triggering code.
//  - A frame register is free if !frm_valid OR (frm_valid & frm_ready) this cycle, so the register
//    reloads back-to-back without a bubble.
//  - Emit while the register is not free: the frame is dropped, buffer/count still clear,
//    overflow<=1, and drop_cnt += nc, saturating at all-ones.
//  - frm_data is stable while frm_valid & !frm_ready. frm_valid drops the cycle after the handshake
//    unless the register is reloaded.
//  - Flush with nc==0: no frame. Flush and code in the same cycle: the code is included in the
//    flushed frame.
//  - ovf_clr with a simultaneous drop: the drop wins (overflow=1, drop_cnt=that drop only).
//  - trc_en=0: the buffer holds its value. The buffer is not auto-flushed.
//  - Two-state control: ACCUM (register empty) / HOLD (frm_valid=1). ACCUM->HOLD on emit;
//    HOLD->ACCUM on handshake without reload; HOLD->HOLD on handshake with reload or no handshake.
// CONFIGURATION
//  SDRAM_NIOS2_QSYS_OCI_DCT_TS_EN defined:
//  - Free-running TS_WIDTH counter, cleared by reset, +1 every cycle, wraps.
//  - The value sampled in the emit cycle goes to frm_data[33+TS_WIDTH:34]; frm_data width is
//    34+TS_WIDTH.
//  Not defined: no counter; frm_data is 34 bits; no other difference.
// TESTING
//  1. Reset, then codes 0,1,2,3 repeated, 15 accepted ->
//     frm_data={4'hF,30'h06C6C6C6_ masked to 30 b} (i.e. 30'h1B1B1B1B>>2 pattern).
//     Check vs model; frm_valid 1 cycle after the 15th code.
//  2. 5 codes of 2'b11, then flush -> frm_data={4'd5,30'h3FF}; dct_count=0 the next cycle.
//  3. Hold frm_ready=0 and feed 30 codes -> the first frame is held stable; the second frame is
//     dropped; overflow=1; drop_cnt=15. ovf_clr -> both 0.
//  4. frm_ready=1 with continuous codes -> a frame every 15 cycles, no bubbles, no overflow
//     over 1000 codes.
//  5. Flush with dct_count=0 -> no frm_valid. Flush plus code at count 3 -> frame count=4.
//  6. Assert reset with count=9 and frm_valid=1 -> next cycle all outputs 0; the following
//     15 codes form a clean frame.
//     With TS_EN: ts field equals cycles since reset at the emit cycle.

Source files
------------

// File: rtl/sdram_nios2_qsys_oci_dct_packer.sv
// Packs 2-bit trace codes into 15-code DCT frames and hands them out over valid/ready; drops and counts codes when the frame register is busy.
// Optional timestamp field in the frame MSBs when SDRAM_NIOS2_QSYS_OCI_DCT_TS_EN is defined.
module sdram_nios2_qsys_oci_dct_packer #(
  parameter int DROP_CNT_W = 8,
  parameter int TS_WIDTH   = 16,
`ifdef SDRAM_NIOS2_QSYS_OCI_DCT_TS_EN
  localparam int FW = 34 + TS_WIDTH
`else
  localparam int FW = 34 + (TS_WIDTH * 0)
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  trc_en,
  input  logic                  code_valid,
  input  logic [1:0]            code,
  input  logic                  flush,
  output logic [29:0]           dct_buffer,
  output logic [3:0]            dct_count,
  output logic                  frm_valid,
  input  logic                  frm_ready,
  output logic [FW-1:0]         frm_data,
  output logic                  overflow,
  input  logic                  ovf_clr,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  typedef enum logic {ACCUM, HOLD} state_e;

  state_e                state_q, state_d;
  logic [29:0]           buf_q, buf_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [FW-1:0]         frm_q, frm_d;
  logic                  ovf_q, ovf_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;

  logic [29:0]           nb;
  logic [3:0]            nc;
  logic                  emit;
  logic                  free;
  logic [DROP_CNT_W-1:0] drop_base;
  logic [DROP_CNT_W:0]   drop_sum;

`ifdef SDRAM_NIOS2_QSYS_OCI_DCT_TS_EN
  logic [TS_WIDTH-1:0]   ts_q, ts_d;

  always_comb ts_d = ts_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_d;
  end
`endif

  always_comb begin
    nb = buf_q;
    nc = cnt_q;
    if (trc_en && code_valid) begin
      nb = {buf_q[27:0], code};
      nc = cnt_q + 4'd1;
    end
    emit      = (nc == 4'd15) || (flush && (nc != 4'd0));
    free      = (state_q == ACCUM) || frm_ready;
    // A drop in the same cycle as ovf_clr restarts the count from this drop alone.
    drop_base = ovf_clr ? '0 : drop_q;
    drop_sum  = {1'b0, drop_base} + (DROP_CNT_W+1)'(nc);

    buf_d   = nb;
    cnt_d   = nc;
    state_d = state_q;
    frm_d   = frm_q;
    ovf_d   = ovf_q & ~ovf_clr;
    drop_d  = drop_base;

    if ((state_q == HOLD) && frm_ready) state_d = ACCUM;

    if (emit) begin
      buf_d = '0;
      cnt_d = '0;
      if (free) begin
        state_d = HOLD;
`ifdef SDRAM_NIOS2_QSYS_OCI_DCT_TS_EN
        frm_d   = {ts_q, nc, nb};
`else
        frm_d   = {nc, nb};
`endif
      end else begin
        ovf_d  = 1'b1;
        drop_d = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACCUM;
      buf_q   <= '0;
      cnt_q   <= '0;
      frm_q   <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      frm_q   <= frm_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  assign dct_buffer = buf_q;
  assign dct_count  = cnt_q;
  assign frm_valid  = (state_q == HOLD);
  assign frm_data   = frm_q;
  assign overflow   = ovf_q;
  assign drop_cnt   = drop_q;

endmodule
